// File: rtl/fp_minmax_reduce.sv
// fp_minmax_reduce
//   Streaming DLFloat16 min/max reduction. Accepts a packet of operands over a
//   valid/ready stream and, once the last operand is taken, presents the extreme
//   value, its packet index and the element count until the result is consumed.
//   Ordering: sign first, then {exp,mant} as sign-magnitude. No NaN/Inf handling.
//
// Configuration macro:
//   FP_REDUCE_NEG_ZERO_EQ_EN  when defined, +0 and -0 compare equal (earlier kept);
//                             otherwise -0 orders below +0.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   mode         0 = min, 1 = max; taken with the first beat of a packet
//   in_data      DLFloat16 operand {s, exp[5:0], mant[8:0]}
//   in_valid     operand valid
//   in_last      final operand of the packet
//   in_ready     engine can accept an operand
//   out_data     reduced value
//   out_idx      packet index of out_data (wraps with the count)
//   out_count    elements accepted, modulo 2**IDX_W
//   out_ovf      packet held more than 2**IDX_W elements
//   out_valid    result valid
//   out_ready    downstream accepts result
module fp_minmax_reduce #(
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [15:0]      out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StHold
  } state_e;

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [15:0]      best_q, best_d;
  logic [IDX_W-1:0] bidx_q, bidx_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  // Result registers are separate from the working set so the previous result
  // stays visible while the next packet accumulates.
  logic [15:0]      res_data_q, res_data_d;
  logic [IDX_W-1:0] res_idx_q, res_idx_d;
  logic [IDX_W-1:0] res_cnt_q, res_cnt_d;
  logic             res_ovf_q, res_ovf_d;

  logic in_beat, out_beat, load_res, replace;

  // Strict "a < b" under the FPU compare ordering.
  function automatic logic fp_less(input logic [15:0] a, input logic [15:0] b);
    logic lt;
    if (a[15] != b[15]) begin
      lt = a[15];
    end else if (a[15]) begin
      lt = a[14:0] > b[14:0];
    end else begin
      lt = a[14:0] < b[14:0];
    end
`ifdef FP_REDUCE_NEG_ZERO_EQ_EN
    if ((a[14:0] == 15'd0) && (b[14:0] == 15'd0)) begin
      lt = 1'b0;
    end
`endif
    return lt;
  endfunction

  assign in_ready  = (state_q != StHold);
  assign out_valid = (state_q == StHold);
  assign in_beat   = in_valid && in_ready;
  assign out_beat  = out_valid && out_ready;

  assign out_data  = res_data_q;
  assign out_idx   = res_idx_q;
  assign out_count = res_cnt_q;
  assign out_ovf   = res_ovf_q;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    best_d     = best_q;
    bidx_d     = bidx_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    res_data_d = res_data_q;
    res_idx_d  = res_idx_q;
    res_cnt_d  = res_cnt_q;
    res_ovf_d  = res_ovf_q;
    load_res   = 1'b0;
    replace    = mode_q ? fp_less(best_q, in_data) : fp_less(in_data, best_q);

    unique case (state_q)
      StIdle: begin
        if (in_beat) begin
          mode_d   = mode;
          best_d   = in_data;
          bidx_d   = '0;
          cnt_d    = IDX_W'(1);
          ovf_d    = 1'b0;
          load_res = in_last;
          state_d  = in_last ? StHold : StAccum;
        end
      end
      StAccum: begin
        if (in_beat) begin
          if (replace) begin
            best_d = in_data;
            bidx_d = cnt_q;
          end
          cnt_d    = cnt_q + IDX_W'(1);
          // A zero count here means 2**IDX_W elements were already taken.
          ovf_d    = ovf_q | (cnt_q == '0);
          load_res = in_last;
          if (in_last) begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (out_beat) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load_res) begin
      res_data_d = best_d;
      res_idx_d  = bidx_d;
      res_cnt_d  = cnt_d;
      res_ovf_d  = ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      mode_q     <= 1'b0;
      best_q     <= '0;
      bidx_q     <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      res_data_q <= '0;
      res_idx_q  <= '0;
      res_cnt_q  <= '0;
      res_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      best_q     <= best_d;
      bidx_q     <= bidx_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      res_data_q <= res_data_d;
      res_idx_q  <= res_idx_d;
      res_cnt_q  <= res_cnt_d;
      res_ovf_q  <= res_ovf_d;
    end
  end

endmodule

// File: tb/tb_fp_minmax_reduce.sv
// Bench for fp_minmax_reduce: a full-width instance (IDX_W=8) and a narrow one
// (IDX_W=2) share every input, so the narrow one exercises count/index wrap.
module tb_fp_minmax_reduce;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_ovf;
  logic [15:0] out_data;
  logic [7:0]  out_idx, out_count;
  logic        s_in_ready, s_out_valid, s_out_ovf;
  logic [15:0] s_out_data;
  logic [1:0]  s_out_idx, s_out_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_minmax_reduce #(.IDX_W(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data), .out_idx(out_idx),
    .out_count(out_count), .out_ovf(out_ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  fp_minmax_reduce #(.IDX_W(2)) dut_s (
    .clk(clk), .rst(rst), .mode(mode), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(s_in_ready), .out_data(s_out_data), .out_idx(s_out_idx),
    .out_count(s_out_count), .out_ovf(s_out_ovf), .out_valid(s_out_valid),
    .out_ready(out_ready)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Total order key: larger key = larger value.
  function automatic int fp_key(input logic [15:0] v);
    int mag;
    mag = int'(v[14:0]);
`ifdef FP_REDUCE_NEG_ZERO_EQ_EN
    return v[15] ? -mag : mag;
`else
    return v[15] ? -mag - 1 : mag;
`endif
  endfunction

  // Reference: full-precision best index, then reduced to the port widths.
  task automatic model(input logic md, input logic [15:0] pk[$], input int w,
                       output logic [15:0] e_data, output int e_idx, output int e_cnt,
                       output logic e_ovf);
    int bi = 0;
    for (int i = 1; i < pk.size(); i++) begin
      if (md ? (fp_key(pk[i]) > fp_key(pk[bi])) : (fp_key(pk[i]) < fp_key(pk[bi]))) bi = i;
    end
    e_data = pk[bi];
    e_idx  = bi % (1 << w);
    e_cnt  = pk.size() % (1 << w);
    e_ovf  = pk.size() > (1 << w);
  endtask

  task automatic drive_beat(input logic md, input logic [15:0] d, input logic last);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    mode     = md;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
  endtask

  task automatic run_packet(input logic md, input logic [15:0] pk[$], input int stall,
                            input int gapmax, input logic [15:0] e_data, input int e_idx,
                            input int e_cnt, input logic e_ovf, input int s_idx,
                            input int s_cnt, input logic s_ovf);
    for (int i = 0; i < pk.size(); i++) begin
      if (i > 0 && gapmax > 0) begin
        repeat ($urandom_range(0, gapmax)) begin
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
      // Only the first beat's mode should matter.
      drive_beat((i == 0) ? md : 1'($urandom), pk[i], i == pk.size() - 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("latency_out_valid", 32'(out_valid), 32'd1);
    check("hold_in_ready", 32'(in_ready), 32'd0);
    check("out_data", 32'(out_data), 32'(e_data));
    check("out_idx", 32'(out_idx), 32'(e_idx));
    check("out_count", 32'(out_count), 32'(e_cnt));
    check("out_ovf", 32'(out_ovf), 32'(e_ovf));
    check("s_out_data", 32'(s_out_data), 32'(e_data));
    check("s_out_idx", 32'(s_out_idx), 32'(s_idx));
    check("s_out_count", 32'(s_out_count), 32'(s_cnt));
    check("s_out_ovf", 32'(s_out_ovf), 32'(s_ovf));
    for (int c = 0; c < stall; c++) begin
      in_valid = 1'b1;
      in_data  = 16'(~e_data);
      in_last  = 1'b1;
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_data", 32'(out_data), 32'(e_data));
      check("stall_out_count", 32'(out_count), 32'(e_cnt));
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_out_data_kept", 32'(out_data), 32'(e_data));
    check("post_out_idx_kept", 32'(out_idx), 32'(e_idx));
  endtask

  typedef struct {
    logic        md;
    int          n;
    logic [15:0] d[8];
    int          stall;
    logic [15:0] e_data;
    int          e_idx, e_cnt;
    logic        e_ovf;
    int          s_idx, s_cnt;
    logic        s_ovf;
  } vec_t;

  initial begin
    vec_t        tbl[6];
    logic [15:0] pk[$];
    logic [15:0] ed;
    int          ei, ec, si, sc;
    logic        eo, so;
    int          n;

    // Reset: hold two cycles, outputs are zero while and after reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid_after", 32'(out_valid), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);

    tbl[0] = '{1'b1, 3, '{16'h3E00, 16'h4000, 16'hBE00, 0, 0, 0, 0, 0}, 0,
               16'h4000, 1, 3, 1'b0, 1, 3, 1'b0};
    tbl[1] = '{1'b0, 3, '{16'h3C00, 16'hBE00, 16'hBE00, 0, 0, 0, 0, 0}, 0,
               16'hBE00, 1, 3, 1'b0, 1, 3, 1'b0};
`ifdef FP_REDUCE_NEG_ZERO_EQ_EN
    tbl[2] = '{1'b0, 2, '{16'h0000, 16'h8000, 0, 0, 0, 0, 0, 0}, 0,
               16'h0000, 0, 2, 1'b0, 0, 2, 1'b0};
`else
    tbl[2] = '{1'b0, 2, '{16'h0000, 16'h8000, 0, 0, 0, 0, 0, 0}, 0,
               16'h8000, 1, 2, 1'b0, 1, 2, 1'b0};
`endif
    tbl[3] = '{1'b1, 1, '{16'h4400, 0, 0, 0, 0, 0, 0, 0}, 5,
               16'h4400, 0, 1, 1'b0, 0, 1, 1'b0};
    tbl[4] = '{1'b1, 5, '{16'h3C00, 16'h3C01, 16'h3C02, 16'h3C03, 16'h4000, 0, 0, 0}, 0,
               16'h4000, 4, 5, 1'b0, 0, 1, 1'b1};
    // Full 4-element packet on the narrow instance: count 0, no overflow.
    tbl[5] = '{1'b0, 4, '{16'hC000, 16'hC200, 16'hBC00, 16'hC200, 0, 0, 0, 0}, 2,
               16'hC200, 1, 4, 1'b0, 1, 0, 1'b0};

    for (int t = 0; t < 6; t++) begin
      pk.delete();
      for (int i = 0; i < tbl[t].n; i++) pk.push_back(tbl[t].d[i]);
      run_packet(tbl[t].md, pk, tbl[t].stall, 0, tbl[t].e_data, tbl[t].e_idx, tbl[t].e_cnt,
                 tbl[t].e_ovf, tbl[t].s_idx, tbl[t].s_cnt, tbl[t].s_ovf);
    end

    // Reset mid-packet discards progress; results go back to reset values.
    drive_beat(1'b1, 16'h5000, 1'b0);
    drive_beat(1'b1, 16'h5100, 1'b0);
    drive_beat(1'b1, 16'h5200, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_out_idx", 32'(out_idx), 32'd0);
    check("midrst_out_count", 32'(out_count), 32'd0);
    check("midrst_out_ovf", 32'(s_out_ovf), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    pk = '{16'h3C00, 16'h4000};
    run_packet(1'b1, pk, 0, 0, 16'h4000, 1, 2, 1'b0, 1, 2, 1'b0);

    // Randomized packets against the reference model.
    for (int p = 0; p < 60; p++) begin
      pk.delete();
      n = (p == 30) ? 300 : int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 7))
          0: pk.push_back(16'h0000);
          1: pk.push_back(16'h8000);
          2: pk.push_back((i > 0) ? pk[$urandom_range(0, i - 1)] : 16'h1234);
          default: pk.push_back(16'($urandom));
        endcase
      end
      mode = 1'($urandom);
      model(mode, pk, 8, ed, ei, ec, eo);
      model(mode, pk, 2, ed, si, sc, so);
      run_packet(mode, pk, int'($urandom_range(0, 2)), 2, ed, ei, ec, eo, si, sc, so);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
